// File: rtl/bch_rx_deframer_if.sv
// Codeword hand-off between the deframer and the BCH(15,7) decoder:
// a registered valid/ready handshake carrying one N-bit word.
interface bch_rx_deframer_if #(
    parameter int N = 15
);
    logic [N-1:0] codeword;
    logic         cw_valid;
    logic         cw_ready;

    modport master (
        output codeword,
        output cw_valid,
        input  cw_ready
    );

    modport slave (
        input  codeword,
        input  cw_valid,
        output cw_ready
    );
endinterface

// File: rtl/bch_rx_deframer.sv
// Serial-to-parallel front end of the BCH(15,7) receiver: frames N-bit words on
// sof_i, hands them to the decoder and counts words lost to backpressure.
module bch_rx_deframer #(
    parameter int N      = 15,
    parameter int DROP_W = 8,
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_i,
    input  logic                  bit_valid_i,
    input  logic                  sof_i,
    input  logic                  clear_i,
    bch_rx_deframer_if.master     cw_if,
    output logic [CNT_W-1:0]      bit_cnt_o,
    output logic                  overflow_o,
    output logic [DROP_W-1:0]     drop_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        sat_inc = (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [N-1:0]      sr_q, sr_d;
    logic [N-1:0]      word_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]      out_q, out_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              complete_s;
    logic              out_free_s;
    logic              load_s;
    logic              drop_s;

    generate
        if (N == 1) begin : g_word_single
            assign word_s = bit_i;
        end else begin : g_word_multi
            assign word_s = {sr_q[N-2:0], bit_i};
        end
    endgenerate

    // A sof_i on what would be the last bit restarts framing instead of completing.
    assign complete_s = bit_valid_i && ((N == 1) || (!sof_i && (cnt_q == CNT_LAST)));
    assign out_free_s = !valid_q || cw_if.cw_ready;
    assign load_s     = complete_s && out_free_s;
    assign drop_s     = complete_s && !out_free_s;

    // Shift register and bit counter; frozen on cycles without a valid bit.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (bit_valid_i) begin
            sr_d = word_s;
            if (complete_s) begin
                cnt_d = '0;
            end else if (sof_i) begin
                cnt_d = CNT_ONE;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
        end
    end

    // Output word register and valid flag; valid only falls after a handshake.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (load_s) begin
            out_d   = word_s;
            valid_d = 1'b1;
        end else if (valid_q && cw_if.cw_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Sticky overflow and saturating drop count; a drop beats a simultaneous clear.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop_s) begin
            ovf_d  = 1'b1;
            drop_d = clear_i ? DROP_W'(1) : sat_inc(drop_q);
        end else if (clear_i) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else begin
            ovf_d  = ovf_q;
            drop_d = drop_q;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    assign cw_if.codeword = out_q;
    assign cw_if.cw_valid = valid_q;
    assign bit_cnt_o      = cnt_q;
    assign overflow_o     = ovf_q;
    assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_bch_rx_deframer.sv
// Scoreboard bench for bch_rx_deframer: stimulus pushes expected codewords,
// a negedge monitor pops them on every handshake; flags are checked directly.
module tb_bch_rx_deframer;

    logic       clk;
    logic       rst_n;
    logic       bit_i;
    logic       bit_valid;
    logic       sof;
    logic       clear;
    logic [3:0] bit_cnt;
    logic       overflow;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [14:0] exp_q[$];
    logic [14:0] lost;

    bch_rx_deframer_if #(.N(15)) cw_if ();

    bch_rx_deframer #(.N(15), .DROP_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_i       (bit_i),
        .bit_valid_i (bit_valid),
        .sof_i       (sof),
        .clear_i     (clear),
        .cw_if       (cw_if),
        .bit_cnt_o   (bit_cnt),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must consume the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && cw_if.cw_valid && cw_if.cw_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word actual=%h required=none", cw_if.codeword);
            end else begin
                check("codeword", {17'd0, cw_if.codeword}, {17'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive_bit(input logic b, input logic s);
        bit_i     = b;
        sof       = s;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [14:0] w, input logic s);
        for (int i = 14; i >= 0; i--) drive_bit(w[i], s && (i == 14));
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        sof       = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_codeword"}, {17'd0, cw_if.codeword}, 32'd0);
        check({tag, "_valid"},    {31'd0, cw_if.cw_valid}, 32'd0);
        check({tag, "_bit_cnt"},  {28'd0, bit_cnt},        32'd0);
        check({tag, "_overflow"}, {31'd0, overflow},       32'd0);
        check({tag, "_drop_cnt"}, {24'd0, drop_cnt},       32'd0);
    endtask

    initial begin
        logic [14:0] w;
        logic [8:0]  part;
        rst_n = 1'b0; bit_i = 1'b0; bit_valid = 1'b0; sof = 1'b0; clear = 1'b0;
        cw_if.cw_ready = 1'b1;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, ready high: valid for exactly one cycle.
        exp_q.push_back(15'h6B1A);
        send_word(15'h6B1A, 1'b1);
        check("t1_valid", {31'd0, cw_if.cw_valid}, 32'd1);
        check("t1_word", {17'd0, cw_if.codeword}, 32'h6B1A);
        check("t1_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        idle(1);
        check("t1_valid_drop", {31'd0, cw_if.cw_valid}, 32'd0);

        // Same word with bit_valid toggling.
        w = 15'h6B1A;
        exp_q.push_back(w);
        for (int i = 14; i >= 0; i--) begin
            if (i == 0) begin
                check("t2_cnt_before_last", {28'd0, bit_cnt}, 32'd14);
                check("t2_valid_before_last", {31'd0, cw_if.cw_valid}, 32'd0);
            end
            drive_bit(w[i], i == 14);
            if (i != 0) idle(1);
        end
        check("t2_valid", {31'd0, cw_if.cw_valid}, 32'd1);
        check("t2_word", {17'd0, cw_if.codeword}, 32'h6B1A);
        idle(2);

        // Partial word discarded by a new sof.
        part = 9'h155;
        for (int i = 8; i >= 0; i--) drive_bit(part[i], i == 8);
        check("t3_partial_cnt", {28'd0, bit_cnt}, 32'd9);
        exp_q.push_back(15'h7FFF);
        send_word(15'h7FFF, 1'b1);
        check("t3_word", {17'd0, cw_if.codeword}, 32'h7FFF);
        check("t3_overflow", {31'd0, overflow}, 32'd0);
        check("t3_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        idle(2);

        // Backpressure: second back-to-back word is dropped.
        cw_if.cw_ready = 1'b0;
        exp_q.push_back(15'h1234);
        send_word(15'h1234, 1'b1);
        check("t4_valid", {31'd0, cw_if.cw_valid}, 32'd1);
        send_word(15'h0F0F, 1'b0);
        idle(1);
        check("t4_word_held", {17'd0, cw_if.codeword}, 32'h1234);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        check("t4_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        cw_if.cw_ready = 1'b1;
        @(posedge clk);
        #1;
        cw_if.cw_ready = 1'b0;
        check("t4_valid_after", {31'd0, cw_if.cw_valid}, 32'd0);
        check("t4_word_kept", {17'd0, cw_if.codeword}, 32'h1234);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("t4_clear_ovf", {31'd0, overflow}, 32'd0);
        check("t4_clear_cnt", {24'd0, drop_cnt}, 32'd0);

        // Word completing on the handshake cycle: no drop, valid stays high.
        exp_q.push_back(15'h2AAA);
        send_word(15'h2AAA, 1'b1);
        w = 15'h5555;
        for (int i = 14; i >= 1; i--) drive_bit(w[i], i == 14);
        exp_q.push_back(w);
        cw_if.cw_ready = 1'b1;
        drive_bit(w[0], 1'b0);
        cw_if.cw_ready = 1'b0;
        check("t5_valid", {31'd0, cw_if.cw_valid}, 32'd1);
        check("t5_word", {17'd0, cw_if.codeword}, 32'h5555);
        check("t5_overflow", {31'd0, overflow}, 32'd0);
        check("t5_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        idle(1);
        cw_if.cw_ready = 1'b1;
        @(posedge clk);
        #1;
        cw_if.cw_ready = 1'b0;
        check("t5_valid_after", {31'd0, cw_if.cw_valid}, 32'd0);

        // 300 drops saturate the counter; clear with a drop leaves one.
        exp_q.push_back(15'h0001);
        repeat (301) send_word(15'h0001, 1'b0);
        check("t6_drop_sat", {24'd0, drop_cnt}, 32'd255);
        check("t6_overflow", {31'd0, overflow}, 32'd1);
        check("t6_word_held", {17'd0, cw_if.codeword}, 32'h0001);
        for (int i = 14; i >= 1; i--) drive_bit(1'b0, 1'b0);
        clear = 1'b1;
        drive_bit(1'b1, 1'b0);
        clear = 1'b0;
        check("t6_clear_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        check("t6_clear_drop_ovf", {31'd0, overflow}, 32'd1);

        // Asynchronous reset mid-word with a pending output word.
        for (int i = 0; i < 7; i++) drive_bit(i[0], i == 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t7_reset");
        lost = exp_q.pop_front();
        bit_valid = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        cw_if.cw_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(15'h3C3C);
        send_word(15'h3C3C, 1'b0);
        check("t7_valid", {31'd0, cw_if.cw_valid}, 32'd1);
        check("t7_word", {17'd0, cw_if.codeword}, 32'h3C3C);
        idle(3);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
